// File: rtl/bnn_neuron_acc.sv
// Binarised-neuron sequencer: streams (x,w) beats through an external
// +/-1 ALU, accumulates onto a bias and hands the sum to the next layer.
module bnn_neuron_acc #(
  parameter int ACC_W = 12,
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_inputs,
  input  logic [ACC_W-1:0] bias,
  input  logic             in_valid,
  input  logic             in_x,
  input  logic             in_w,
  output logic             in_ready,
  output logic             alu_a_lsb,
  output logic             alu_op,
  output logic [ACC_W-1:0] alu_b,
  input  logic [ACC_W-1:0] alu_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_act,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] bias_q, bias_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             beat;

  assign beat = in_valid && in_ready_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    bias_d  = bias_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d     = n_inputs;
          bias_d  = bias;
          acc_d   = bias;
          cnt_d   = '0;
          state_d = (n_inputs == '0) ? DONE : ACC;
        end
      end
      ACC: begin
        if (beat) begin
          acc_d = alu_result;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == n_q) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // handshake outputs are decoded from the next state so they stay registered
    in_ready_d  = (state_d == ACC);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      bias_q      <= '0;
      cnt_q       <= '0;
      n_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      bias_q      <= bias_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign alu_a_lsb = 1'b1;
  assign alu_op    = in_x ^ in_w;
  assign alu_b     = acc_q;
  assign out_sum   = acc_q;
  assign out_act   = ~acc_q[ACC_W-1];

endmodule

// File: tb/tb_bnn_neuron_acc.sv
// Bench for bnn_neuron_acc: table vectors, hand sequences and random
// evaluations checked against a counting model of the neuron.
module tb_bnn_neuron_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [10:0] n_inputs;
  logic [11:0] bias;
  logic        in_valid;
  logic        in_x;
  logic        in_w;
  logic        in_ready;
  logic        alu_a_lsb;
  logic        alu_op;
  logic [11:0] alu_b;
  logic [11:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_sum;
  logic        out_act;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit qx[$];
  bit qw[$];

  always #5 clk = ~clk;

  // downstream +/-1 ALU stage
  assign alu_result = alu_op ? alu_b - 12'd1 : alu_b + 12'd1;

  bnn_neuron_acc dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n_inputs(n_inputs),
    .bias(bias), .in_valid(in_valid), .in_x(in_x), .in_w(in_w),
    .in_ready(in_ready), .alu_a_lsb(alu_a_lsb), .alu_op(alu_op),
    .alu_b(alu_b), .alu_result(alu_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_act(out_act),
    .busy(busy)
  );

  typedef struct {
    int          n;
    logic [11:0] b;
    logic [15:0] xs;
    logic [15:0] ws;
    int          stall_after;
    int          rdy_delay;
    logic [11:0] exp_sum;
    bit          exp_act;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // expected sum from the rules: bias plus matches minus mismatches
  function automatic int model_sum(input int b);
    int s = b;
    foreach (qx[k]) s += (qx[k] == qw[k]) ? 1 : -1;
    return s;
  endfunction

  task automatic run_eval(input int n, input logic [11:0] b,
                          input int stall_after, input bit rand_stall,
                          input int rdy_delay, input int mid_start_at,
                          input logic [11:0] exp_sum, input bit exp_act);
    int i, steps, stalls, lim, pend;
    logic [11:0] acc_m;
    bit drv;
    start = 1'b1;
    n_inputs = n[10:0];
    bias = b;
    step();
    start = 1'b0;
    steps = 1;
    i = 0;
    stalls = 0;
    pend = 0;
    acc_m = b;
    lim = 4 * n + 64;
    while (!out_valid && steps < lim) begin
      drv = 1'b0;
      if (in_ready) begin
        drv = (pend == 0) && (i < qx.size()) &&
              !(rand_stall && $urandom_range(0, 3) == 0);
        if (pend > 0) pend--;
        if (!drv) stalls++;
      end
      in_valid = drv;
      if (drv) begin
        in_x = qx[i];
        in_w = qw[i];
      end else begin
        in_x = 1'($urandom);
        in_w = 1'($urandom);
      end
      if (i == mid_start_at && in_ready) begin
        start = 1'b1;
        n_inputs = 11'd3;
        bias = 12'd100;
      end
      #1;
      if (drv) begin
        chk("alu_op", alu_op, in_x ^ in_w);
        chk("alu_b", alu_b, acc_m);
        chk("alu_a_lsb", alu_a_lsb, 1'b1);
      end
      step();
      start = 1'b0;
      steps++;
      if (drv) begin
        acc_m = (qx[i] == qw[i]) ? acc_m + 12'd1 : acc_m - 12'd1;
        i++;
        if (i == stall_after) pend = 2;
      end
    end
    in_valid = 1'b0;
    chk("out_valid_timeout", out_valid, 1'b1);
    chk("latency", steps, n + 1 + stalls);
    chk("out_sum", out_sum, exp_sum);
    chk("out_act", out_act, exp_act);
    chk("done_busy", busy, 1'b1);
    chk("done_in_ready", in_ready, 1'b0);
    for (int k = 0; k < rdy_delay; k++) begin
      start = (k == 0);
      n_inputs = 11'd9;
      bias = 12'd50;
      step();
      start = 1'b0;
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_sum", out_sum, exp_sum);
    end
    out_ready = 1'b1;
    start = 1'b1;
    n_inputs = 11'd5;
    bias = 12'd77;
    step();
    out_ready = 1'b0;
    start = 1'b0;
    chk("post_valid", out_valid, 1'b0);
    chk("post_busy", busy, 1'b0);
    chk("post_in_ready", in_ready, 1'b0);
  endtask

  task automatic load_bits(input int n, input logic [15:0] xs,
                           input logic [15:0] ws);
    qx.delete();
    qw.delete();
    for (int k = 0; k < n; k++) begin
      qx.push_back(xs[k]);
      qw.push_back(ws[k]);
    end
  endtask

  initial begin
    int bi, n, s;
    rst_n = 1'b0;
    start = 1'b0;
    n_inputs = '0;
    bias = '0;
    in_valid = 1'b0;
    in_x = 1'b0;
    in_w = 1'b0;
    out_ready = 1'b0;

    tbl[0] = '{4, 12'd0, 16'h000D, 16'h0009, -1, 0, 12'd2, 1'b1};
    tbl[1] = '{3, 12'hFFF, 16'h0007, 16'h0000, -1, 3, 12'hFFC, 1'b0};
    tbl[2] = '{5, 12'd2, 16'h001F, 16'h001F, 2, 0, 12'd7, 1'b1};
    tbl[3] = '{0, 12'd5, 16'h0000, 16'h0000, -1, 2, 12'd5, 1'b1};
    tbl[4] = '{16, 12'd0, 16'hFFFF, 16'h0000, -1, 1, 12'hFF0, 1'b0};
    tbl[5] = '{8, 12'h7F0, 16'h0000, 16'h0000, -1, 0, 12'h7F8, 1'b1};
    tbl[6] = '{1, 12'd0, 16'h0000, 16'h0001, -1, 0, 12'hFFF, 1'b0};
    tbl[7] = '{2, 12'd0, 16'h0001, 16'h0003, -1, 0, 12'd0, 1'b1};

    step();
    step();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sum", out_sum, 12'd0);
    chk("rst_out_act", out_act, 1'b1);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    step();

    foreach (tbl[v]) begin
      load_bits(tbl[v].n, tbl[v].xs, tbl[v].ws);
      run_eval(tbl[v].n, tbl[v].b, tbl[v].stall_after, 1'b0,
               tbl[v].rdy_delay, -1, tbl[v].exp_sum, tbl[v].exp_act);
    end

    // reset in the middle of an accumulation
    start = 1'b1;
    n_inputs = 11'd6;
    bias = 12'd0;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    in_x = 1'b1;
    in_w = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_sum", out_sum, 12'd0);
    chk("midrst_in_ready", in_ready, 1'b0);
    chk("midrst_out_valid", out_valid, 1'b0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    step();
    load_bits(1, 16'h0000, 16'h0001);
    run_eval(1, 12'd0, -1, 1'b0, 0, -1, 12'hFFF, 1'b0);

    // full-length run with a start pulse injected mid-stream
    qx.delete();
    qw.delete();
    for (int k = 0; k < 2047; k++) begin
      qx.push_back(k[0]);
      qw.push_back(k[0]);
    end
    run_eval(2047, 12'd0, -1, 1'b0, 0, 1000, 12'h7FF, 1'b1);

    for (int r = 0; r < 20; r++) begin
      n = int'($urandom_range(1, 60));
      bi = int'($urandom_range(0, 400)) - 200;
      qx.delete();
      qw.delete();
      for (int k = 0; k < n; k++) begin
        qx.push_back(1'($urandom));
        qw.push_back(1'($urandom));
      end
      s = model_sum(bi);
      run_eval(n, bi[11:0], -1, 1'b1, int'($urandom_range(0, 3)), -1,
               s[11:0], s >= 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
